spi_request_arbiter: RTL and testbench

//  Shares one SPI Master (8-bit, slaveSelect-driven CS) among N_REQ requesters.

---
 rtl/spi_request_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_request_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_request_arbiter.sv
// -----------------------------------------------------------------------------
// spi_request_arbiter
//
// Shares one 8-bit SPI Master (slaveSelect-driven chip select) among N_REQ
// requesters. A round-robin arbiter picks one pending request while idle. The
// sequencer then runs the transfer: latch the winner's select and byte, pulse
// the Master's start, time the shift, and capture the received byte. It then
// holds the bus deselected for an inter-transfer gap so the Master's chip
// select returns to all-ones before the next transfer.
//
// Ports
//   clk               in   system clock (also the Master's SCLK source)
//   reset             in   asynchronous, active-low reset
//   req               in   [N_REQ]          request level per requester
//   req_sel           in   [2*N_REQ]        slave select per requester, [2i+1:2i]
//   req_data          in   [DATA_W*N_REQ]   byte to send per requester, slice i
//   gnt               out  [N_REQ]          one-hot 1-cycle pulse: request accepted
//   rsp_valid         out  [N_REQ]          one-hot 1-cycle pulse: rsp_data valid
//   rsp_data          out  [DATA_W]         received byte, held until next rsp_valid
//   busy              out                   high whenever the sequencer is not idle
//   spi_start         out                   Master start, 1-cycle pulse
//   spi_slave_select  out  [2]              Master slaveSelect (2'b11 = none)
//   spi_data_to_send  out  [DATA_W]         Master masterDataToSend
//   spi_data_received in   [DATA_W]         Master masterDataReceived
// -----------------------------------------------------------------------------
module spi_request_arbiter #(
    parameter int N_REQ       = 3,
    parameter int DATA_W      = 8,
    parameter int XFER_CYCLES = 10,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [2*N_REQ-1:0]      req_sel,
    input  logic [DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    busy,
    output logic                    spi_start,
    output logic [1:0]              spi_slave_select,
    output logic [DATA_W-1:0]       spi_data_to_send,
    input  logic [DATA_W-1:0]       spi_data_received
);

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0]       NO_SLAVE  = 2'b11;
    localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(XFER_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        XFER,
        CAPTURE,
        GAP
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   rr_ptr, rr_d;
    logic [IDX_W-1:0]   owner, owner_d;
    logic [1:0]         sel_q, sel_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   cnt, cnt_d;

    logic [N_REQ-1:0]   gnt_d;
    logic [N_REQ-1:0]   rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_d;
    logic               start_d;
    logic [1:0]         ss_d;
    logic [DATA_W-1:0]  dts_d;

    logic [1:0]         sel_arr  [N_REQ];
    logic [DATA_W-1:0]  data_arr [N_REQ];
    logic [IDX_W-1:0]   win;

    // First set request at or after ptr, wrapping N_REQ-1 -> 0.
    function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] r,
                                              input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] w;
        logic             found;
        int               idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && r[IDX_W'(idx)]) begin
                w     = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            sel_arr[i]  = req_sel[2*i +: 2];
            data_arr[i] = req_data[DATA_W*i +: DATA_W];
        end
    end

    assign win = pick(req, rr_ptr);

    // Next-state and next-output logic; every output is registered below so
    // nothing on req reaches gnt or spi_* combinationally.
    always_comb begin
        state_d     = state;
        rr_d        = rr_ptr;
        owner_d     = owner;
        sel_d       = sel_q;
        data_d      = data_q;
        cnt_d       = cnt;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data;
        start_d     = 1'b0;
        ss_d        = spi_slave_select;
        dts_d       = spi_data_to_send;

        case (state)
            IDLE: begin
                if (|req) begin
                    state_d     = LAUNCH;
                    owner_d     = win;
                    sel_d       = sel_arr[win];
                    data_d      = data_arr[win];
                    gnt_d[win]  = 1'b1;
                    ss_d        = sel_arr[win];
                    dts_d       = data_arr[win];
                    // No start for a request addressed to no slave.
                    start_d     = (sel_arr[win] != NO_SLAVE);
                end
            end
            LAUNCH: begin
                cnt_d = '0;
                if (sel_q != NO_SLAVE) begin
                    state_d = XFER;
                end else begin
                    // No-op transfer: respond immediately with a zero byte.
                    state_d            = CAPTURE;
                    rsp_valid_d[owner] = 1'b1;
                    rsp_data_d         = '0;
                    rr_d               = next_idx(owner);
                end
            end
            XFER: begin
                if (cnt == XFER_LAST) begin
                    state_d            = CAPTURE;
                    cnt_d              = '0;
                    rsp_valid_d[owner] = 1'b1;
                    rsp_data_d         = spi_data_received;
                    rr_d               = next_idx(owner);
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            CAPTURE: begin
                state_d = GAP;
                cnt_d   = '0;
                ss_d    = NO_SLAVE;
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            sel_q  <= NO_SLAVE;
            data_q <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_d;
            rr_ptr <= rr_d;
            owner  <= owner_d;
            sel_q  <= sel_d;
            data_q <= data_d;
            cnt    <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt              <= '0;
            rsp_valid        <= '0;
            rsp_data         <= '0;
            busy             <= 1'b0;
            spi_start        <= 1'b0;
            spi_slave_select <= NO_SLAVE;
            spi_data_to_send <= '0;
        end else begin
            gnt              <= gnt_d;
            rsp_valid        <= rsp_valid_d;
            rsp_data         <= rsp_data_d;
            busy             <= (state_d != IDLE);
            spi_start        <= start_d;
            spi_slave_select <= ss_d;
            spi_data_to_send <= dts_d;
        end
    end

endmodule

// File: tb/tb_spi_request_arbiter.sv
module tb_spi_request_arbiter;

    localparam int N_REQ       = 3;
    localparam int DATA_W      = 8;
    localparam int XFER_CYCLES = 10;
    localparam int GAP_CYCLES  = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req;
    logic [2*N_REQ-1:0]      req_sel;
    logic [DATA_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    busy;
    logic                    spi_start;
    logic [1:0]              spi_slave_select;
    logic [DATA_W-1:0]       spi_data_to_send;
    logic [DATA_W-1:0]       spi_data_received;

    spi_request_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W),
        .XFER_CYCLES(XFER_CYCLES), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_sel(req_sel), .req_data(req_data),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .spi_start(spi_start), .spi_slave_select(spi_slave_select),
        .spi_data_to_send(spi_data_to_send), .spi_data_received(spi_data_received)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                idx;
        logic [1:0]        sel;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] rsp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Loopback Master: after a start, MISO returns the sent byte exactly
    // XFER_CYCLES cycles later; before that it shows a filler byte.
    int                mcnt = 0;
    logic [DATA_W-1:0] mdata;
    initial spi_data_received = '0;
    always @(negedge clk) begin
        if (spi_start) begin
            mcnt              = 1;
            mdata             = spi_data_to_send;
            spi_data_received = 8'hEE;
        end else if (mcnt != 0) begin
            mcnt++;
            if (mcnt == XFER_CYCLES + 1) begin
                spi_data_received = mdata;
                mcnt              = 0;
            end
        end
    end

    // Monitor / scoreboard
    int   ncyc = 0;
    int   gnt_cyc, last_rsp;
    bit   active = 0, have_last = 0, cs_ok, extra_start;
    exp_t cur;
    always @(negedge clk) begin
        ncyc++;
        if (!reset) begin
            active    = 0;
            have_last = 0;
        end else begin
            if (gnt != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_gnt", 32'(gnt), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("gnt", 32'(gnt), 32'(1 << cur.idx));
                    chk("spi_start_at_gnt", 32'(spi_start), 32'(cur.sel != 2'b11));
                    chk("slave_select_at_gnt", 32'(spi_slave_select), 32'(cur.sel));
                    chk("data_to_send_at_gnt", 32'(spi_data_to_send), 32'(cur.data));
                    chk("busy_at_gnt", 32'(busy), 32'd1);
                    if (have_last)
                        chk("gap_before_gnt", 32'((ncyc - last_rsp) > GAP_CYCLES), 32'd1);
                    gnt_cyc     = ncyc;
                    active      = 1;
                    cs_ok       = 1;
                    extra_start = 0;
                end
            end else if (active && rsp_valid == 0) begin
                if (spi_slave_select !== cur.sel || spi_data_to_send !== cur.data) cs_ok = 0;
                if (spi_start) extra_start = 1;
            end
            if (rsp_valid != 0) begin
                if (!active) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    chk("rsp_valid", 32'(rsp_valid), 32'(1 << cur.idx));
                    chk("rsp_data", 32'(rsp_data), 32'(cur.rsp));
                    chk("rsp_latency", 32'(ncyc - gnt_cyc),
                        32'((cur.sel == 2'b11) ? 1 : XFER_CYCLES + 1));
                    chk("cs_data_stable", 32'(cs_ok), 32'd1);
                    chk("single_start", 32'(extra_start), 32'd0);
                    active    = 0;
                    last_rsp  = ncyc;
                    have_last = 1;
                end
            end
        end
    end

    task automatic set_src(input int idx, input logic [1:0] sel, input logic [DATA_W-1:0] data);
        req_sel[2*idx +: 2]           = sel;
        req_data[DATA_W*idx +: DATA_W] = data;
    endtask

    task automatic expect_xfer(input int idx, input logic [1:0] sel, input logic [DATA_W-1:0] data);
        exp_t e;
        e.idx  = idx;
        e.sel  = sel;
        e.data = data;
        e.rsp  = (sel == 2'b11) ? '0 : data;
        exp_q.push_back(e);
    endtask

    task automatic wait_gnt(input int idx);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (gnt[idx]) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_gnt%0d: no grant within 100 cycles", idx);
        end
    endtask

    task automatic wait_rsp(input int idx);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid[idx]) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_rsp%0d: no response within 100 cycles", idx);
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && !active) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_idle: still busy after 200 cycles");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_spi_start"}, 32'(spi_start), 32'd0);
        chk({tag, "_slave_select"}, 32'(spi_slave_select), 32'h3);
        chk({tag, "_data_to_send"}, 32'(spi_data_to_send), 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        req      = '0;
        req_sel  = '1;
        req_data = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reset mid-transfer aborts it; pending req[1] then gets a fresh transfer.
        set_src(0, 2'b01, 8'h3C);
        expect_xfer(0, 2'b01, 8'h3C);
        req = 3'b001;
        wait_gnt(0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        req = 3'b010;
        set_src(1, 2'b10, 8'h5A);
        repeat (2) @(negedge clk);
        chk("abort_busy_held", 32'(busy), 32'd0);
        expect_xfer(1, 2'b10, 8'h5A);
        reset = 1'b1;
        wait_gnt(1);
        req = '0;
        wait_idle();

        // Single loopback transfer to slave 1.
        set_src(0, 2'b01, 8'hA5);
        expect_xfer(0, 2'b01, 8'hA5);
        req = 3'b001;
        wait_gnt(0);
        req = '0;
        wait_idle();

        // No-slave request: immediate zero response, no start.
        set_src(2, 2'b11, 8'h77);
        expect_xfer(2, 2'b11, 8'h77);
        req = 3'b100;
        wait_gnt(2);
        req = '0;
        wait_idle();

        // All three held: round-robin 0,1,2,0.
        set_src(0, 2'b01, 8'h11);
        set_src(1, 2'b10, 8'h22);
        set_src(2, 2'b00, 8'h33);
        expect_xfer(0, 2'b01, 8'h11);
        expect_xfer(1, 2'b10, 8'h22);
        expect_xfer(2, 2'b00, 8'h33);
        expect_xfer(0, 2'b01, 8'h11);
        req = 3'b111;
        wait_gnt(0);
        wait_gnt(1);
        wait_gnt(2);
        wait_gnt(0);
        req = '0;
        wait_idle();

        // req[0] withdrawn just before idle sampling while req[1] rises.
        set_src(2, 2'b01, 8'h99);
        set_src(1, 2'b10, 8'h5B);
        expect_xfer(2, 2'b01, 8'h99);
        expect_xfer(1, 2'b10, 8'h5B);
        req = 3'b100;
        wait_gnt(2);
        req = 3'b001;
        wait_rsp(2);
        repeat (GAP_CYCLES) @(negedge clk);
        req = 3'b010;
        wait_gnt(1);
        req = '0;
        wait_idle();

        // req[1] held, req[0] re-pulsed in each gap: grants alternate 0/1.
        set_src(0, 2'b00, 8'h50);
        set_src(1, 2'b10, 8'h61);
        expect_xfer(0, 2'b00, 8'h50);
        expect_xfer(1, 2'b10, 8'h61);
        expect_xfer(0, 2'b00, 8'h50);
        expect_xfer(1, 2'b10, 8'h61);
        req = 3'b011;
        for (int k = 0; k < 2; k++) begin
            wait_gnt(0);
            req[0] = 1'b0;
            wait_gnt(1);
            if (k == 0) begin
                wait_rsp(1);
                req[0] = 1'b1;
            end else begin
                req = '0;
            end
        end
        wait_idle();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
